// File: rtl/pixel_scan_ctrl.sv
// Pixel scan controller: walks row/col over one active frame, freezes the
// filter selection per frame and carries valid/sof/eol/eof tags through a
// PIPE_DEPTH-stage pipeline that stalls on downstream backpressure.
module pixel_scan_ctrl #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  filter_SW,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [12:0] row,
  output logic [12:0] col,
  output logic [5:0]  filter_sel,
  output logic        pix_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sof,
  output logic        eol,
  output logic        eof,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [12:0] HLast = 13'(H_ACTIVE - 1);
  localparam logic [12:0] VLast = 13'(V_ACTIVE - 1);
  localparam int unsigned Last  = PIPE_DEPTH - 1;

  typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

  state_e                  state_q, state_d;
  logic [12:0]             row_q, row_d;
  logic [12:0]             col_q, col_d;
  logic [5:0]              filt_q, filt_d;
  logic                    done_q, done_d;
  logic [PIPE_DEPTH-1:0]   vld_q, vld_d;
  logic [PIPE_DEPTH-1:0]   sof_q, sof_d;
  logic [PIPE_DEPTH-1:0]   eol_q, eol_d;
  logic [PIPE_DEPTH-1:0]   eof_q, eof_d;

  logic advance;
  logic ready_raw;
  logic accept;
  logic at_eol;
  logic at_eof;
  logic eof_take;

  // Handshake decode shared by the FSM and the tag pipeline
  always_comb begin
    advance   = out_ready || !vld_q[Last];
    ready_raw = (state_q == StActive) && advance;
    accept    = in_valid && ready_raw;
    at_eol    = (col_q == HLast);
    at_eof    = at_eol && (row_q == VLast);
    eof_take  = vld_q[Last] && out_ready && eof_q[Last];
  end

  // Scan FSM: frame start, raster counters, flush until eof leaves the pipe
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    filt_d  = filt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          filt_d  = filter_SW;
          state_d = StActive;
        end
      end
      StActive: begin
        if (accept) begin
          // Last pixel keeps its coordinates; counters never wrap past the frame
          if (at_eof) begin
            state_d = StFlush;
          end else if (at_eol) begin
            col_d = '0;
            row_d = row_q + 13'd1;
          end else begin
            col_d = col_q + 13'd1;
          end
        end
      end
      StFlush: begin
        if (eof_take) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tag pipeline: shifts only on advance, so a stalled output holds every tag
  always_comb begin
    vld_d = vld_q;
    sof_d = sof_q;
    eol_d = eol_q;
    eof_d = eof_q;
    if (advance) begin
      vld_d[0] = accept;
      sof_d[0] = accept && (row_q == '0) && (col_q == '0);
      eol_d[0] = accept && at_eol;
      eof_d[0] = accept && at_eof;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
        vld_d[i] = vld_q[i-1];
        sof_d[i] = sof_q[i-1];
        eol_d[i] = eol_q[i-1];
        eof_d[i] = eof_q[i-1];
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      filt_q  <= '0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      sof_q   <= '0;
      eol_q   <= '0;
      eof_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      filt_q  <= filt_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  // Handshake outputs are masked while rst is high, before the reset edge lands
  always_comb begin
    in_ready   = ready_raw && !rst;
    pix_en     = accept && !rst;
    out_valid  = vld_q[Last] && !rst;
    sof        = sof_q[Last] && !rst;
    eol        = eol_q[Last] && !rst;
    eof        = eof_q[Last] && !rst;
    busy       = (state_q != StIdle) && !rst;
    frame_done = done_q;
    row        = row_q;
    col        = col_q;
    filter_sel = filt_q;
  end

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Scoreboard bench for pixel_scan_ctrl on a reduced 10x5 frame.
module tb_pixel_scan_ctrl;

  localparam int H    = 10;
  localparam int V    = 5;
  localparam int PD   = 2;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [5:0]  filter_SW;
  logic        in_ready, pix_en, out_valid, sof, eol, eof, busy, frame_done;
  logic [12:0] row, col;
  logic [5:0]  filter_sel;

  pixel_scan_ctrl #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .filter_SW  (filter_SW),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .row        (row),
    .col        (col),
    .filter_sel (filter_sel),
    .pix_en     (pix_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sof        (sof),
    .eol        (eol),
    .eof        (eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  tag_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_acc_cyc = 0;
  bit         ideal = 1'b0;
  bit         eof_pop_now = 1'b0;
  int         m_k = 0;
  bit         m_busy = 1'b0;
  bit         m_done_exp = 1'b0;
  logic [5:0] m_filter = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (!frame_done && n < max_cycles) begin
      step();
      n++;
    end
    tests++;
    if (!frame_done) begin
      fails++;
      $display("FAIL frame_done_timeout: got no frame_done, expected one within %0d cycles",
               max_cycles);
    end
  endtask

  // Monitor: pops expected tags whenever the DUT hands an output downstream
  initial begin
    tag_t     e;
    bit       prev_stall = 1'b0;
    logic [2:0] prev_tags = '0;
    int       sof_cnt = 0;
    int       eol_cnt = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      eof_pop_now = 1'b0;
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
        sof_cnt = 0;
        eol_cnt = 0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_valid", 32'(out_valid), 32'd1);
          check("stall_hold_tags", 32'({sof, eol, eof}), 32'(prev_tags));
        end
        if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
        if (out_valid && out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL spurious_output: got out_valid=1, expected no pending pixel");
          end else begin
            e = exp_q.pop_front();
            check("out_tags", 32'({sof, eol, eof}), 32'({e.sof, e.eol, e.eof}));
            if (sof) sof_cnt++;
            if (eol) eol_cnt++;
            if (e.eof) begin
              check("frame_sof_count", 32'(sof_cnt), 32'd1);
              check("frame_eol_count", 32'(eol_cnt), 32'(V));
              sof_cnt = 0;
              eol_cnt = 0;
              eof_pop_now = 1'b1;
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_tags  = {sof, eol, eof};
      end
    end
  end

  // Reference model: frame position as a flat pixel index, frame state as a flag
  initial begin
    tag_t t;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      check("busy", 32'(m_busy && !rst), 32'(busy));
      check("filter_sel", 32'(filter_sel), 32'(m_filter));
      check("frame_done", 32'(frame_done), 32'(m_done_exp));
      if (ideal && frame_done) check("done_latency", 32'(cyc - last_acc_cyc), 32'(PD + 1));
      if (rst) check("reset_outputs", 32'({in_ready, out_valid, pix_en, sof, eol, eof}), 32'd0);
      if (!m_busy || m_k == NPIX) check("in_ready_low", 32'(in_ready), 32'd0);
      if (pix_en && m_k < NPIX) begin
        check("row", 32'(row), 32'(m_k / H));
        check("col", 32'(col), 32'(m_k % H));
        t.sof = (m_k == 0);
        t.eol = ((m_k % H) == H - 1);
        t.eof = (m_k == NPIX - 1);
        exp_q.push_back(t);
        m_k++;
        if (m_k == NPIX) last_acc_cyc = cyc;
      end
      m_done_exp = !rst && eof_pop_now;
      if (rst) begin
        m_busy   = 1'b0;
        m_k      = 0;
        m_filter = '0;
      end else if (!m_busy && start) begin
        m_busy   = 1'b1;
        m_k      = 0;
        m_filter = filter_SW;
      end else if (m_busy && eof_pop_now) begin
        m_busy = 1'b0;
      end
    end
  end

  // Random traffic until the current frame completes
  task automatic random_frame(input bit with_stall);
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (with_stall && i >= 15 && i < 25) ? 1'b0 : ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 7) == 0);
      filter_SW = 6'($urandom);
      step();
      if (frame_done) break;
    end
    start = 1'b0;
    tests++;
    if (!frame_done) begin
      fails++;
      $display("FAIL random_frame_timeout: got no frame_done, expected one within 3000 cycles");
    end
  endtask

  // Stimulus
  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    filter_SW = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Ideal frame: constant valid/ready, filter change and start mid-frame
    filter_SW = 6'h05;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    ideal     = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    repeat (12) step();
    filter_SW = 6'h2A;
    start     = 1'b1;
    step();
    start = 1'b0;
    wait_done(200);
    check("filter_frozen", 32'(filter_sel), 32'h05);
    step();
    ideal = 1'b0;

    // Random frame with a forced 10-cycle output stall
    start = 1'b1;
    step();
    random_frame(1'b1);
    step();

    // Start held through eof consumption: restart only after an idle cycle
    in_valid  = 1'b1;
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    wait_done(200);
    step();
    start = 1'b0;

    // Reset mid-frame, then a clean frame from (0,0)
    for (int n = 0; n < 200 && row != 13'd2; n++) step();
    check("reached_row2", 32'(row), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_filter_sel", 32'(filter_sel), 32'd0);
    repeat (3) step();
    check("no_done_after_rst", 32'(frame_done), 32'd0);
    filter_SW = 6'h11;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("restart_row", 32'(row), 32'd0);
    check("restart_col", 32'(col), 32'd0);
    random_frame(1'b0);
    repeat (4) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
